// File: rtl/oled_update_scheduler.sv
// AHB-Lite register front end and refresh scheduler for the OLED serializer.
// Tracks per-block shadow/shown pictures and issues one job at a time, round-robin.
module oled_update_scheduler #(
  parameter int NUM_BLOCKS = 20,
  parameter int RES_W      = 5
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic             HWRITE,
  input  logic [1:0]       HTRANS,
  input  logic [31:0]      HADDR,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             job_valid,
  input  logic             job_ready,
  input  logic             job_done,
  output logic             job_is_cmd,
  output logic [7:0]       job_cmd,
  output logic [4:0]       job_block,
  output logic [RES_W-1:0] job_resource,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PICK, S_WAIT_ACC, S_WAIT_DONE} state_t;

  state_t state_q, state_d;
  logic dp_vld_q, dp_vld_d, dp_wr_q, dp_wr_d;
  logic [5:0] dp_addr_q, dp_addr_d;
  logic enable_q, enable_d, night_q, night_d, last_night_q, last_night_d;
  logic [NUM_BLOCKS-1:0][RES_W-1:0] shadow_q, shadow_d, shown_q, shown_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  logic [4:0] rr_ptr_q, rr_ptr_d, job_block_q, job_block_d;
  logic [RES_W-1:0] job_res_q, job_res_d;
  logic job_is_cmd_q, job_is_cmd_d;
  logic [7:0] job_cmd_q, job_cmd_d;

  logic [5:0] blk_off;
  logic [4:0] blk_idx, pick_idx;
  logic blk_hit, wr_en, any_dirty, in_flight, pick_found, refresh;
  logic [RES_W-1:0] wval;
  int j;

  assign HREADYOUT    = 1'b1;
  assign job_valid    = (state_q == S_WAIT_ACC);
  assign busy         = (state_q == S_WAIT_ACC) || (state_q == S_WAIT_DONE);
  assign job_is_cmd   = job_is_cmd_q;
  assign job_cmd      = job_cmd_q;
  assign job_block    = job_block_q;
  assign job_resource = job_res_q;
  assign any_dirty    = |dirty_q;
  assign in_flight    = busy && !job_is_cmd_q;
  assign blk_off      = dp_addr_q - 6'd16;
  assign blk_idx      = blk_off[4:0];
  assign blk_hit      = (dp_addr_q >= 6'd16) && (int'(blk_off) < NUM_BLOCKS);
  assign wr_en        = dp_vld_q && dp_wr_q && HREADY;
  assign wval         = HWDATA[RES_W-1:0];

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:8], HADDR[1:0], HWDATA, HTRANS[0], blk_off[5]};

  // Scan downward so the last hit is the closest dirty block after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = NUM_BLOCKS; k >= 1; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_BLOCKS) j = j - NUM_BLOCKS;
      if (dirty_q[j[4:0]]) begin
        pick_found = 1'b1;
        pick_idx   = j[4:0];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_vld_q && !dp_wr_q) begin
      case (dp_addr_q)
        6'd0:    HRDATA = {31'b0, enable_q};
        6'd1:    HRDATA = {19'b0, rr_ptr_q, 6'b0, any_dirty, busy};
        6'd2:    HRDATA = {31'b0, night_q};
        6'd3:    HRDATA = 32'(dirty_q);
        default: if (blk_hit) HRDATA = 32'(shadow_q[blk_idx]);
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    dp_vld_d     = dp_vld_q;
    dp_wr_d      = dp_wr_q;
    dp_addr_d    = dp_addr_q;
    enable_d     = enable_q;
    night_d      = night_q;
    last_night_d = last_night_q;
    shadow_d     = shadow_q;
    shown_d      = shown_q;
    dirty_d      = dirty_q;
    rr_ptr_d     = rr_ptr_q;
    job_block_d  = job_block_q;
    job_res_d    = job_res_q;
    job_is_cmd_d = job_is_cmd_q;
    job_cmd_d    = job_cmd_q;
    refresh      = 1'b0;

    if (HREADY) begin
      dp_vld_d  = HSEL && HTRANS[1];
      dp_wr_d   = HWRITE;
      dp_addr_d = HADDR[7:2];
    end

    if (wr_en) begin
      case (dp_addr_q)
        6'd0: begin
          enable_d = HWDATA[0];
          refresh  = HWDATA[1];
        end
        6'd2: night_d = HWDATA[0];
        default: if (blk_hit) begin
          shadow_d[blk_idx] = wval;
          // A block already handed out will become shown as job_resource.
          if (in_flight && job_block_q == blk_idx) dirty_d[blk_idx] = (wval != job_res_q);
          else                                     dirty_d[blk_idx] = (wval != shown_q[blk_idx]);
        end
      endcase
    end

    case (state_q)
      S_IDLE: if (enable_q) begin
        if (night_q != last_night_q) state_d = S_CMD;
        else if (any_dirty)          state_d = S_PICK;
      end
      S_CMD: begin
        job_is_cmd_d = 1'b1;
        job_cmd_d    = night_q ? 8'hA7 : 8'hA6;
        last_night_d = night_q;
        state_d      = S_WAIT_ACC;
      end
      S_PICK: begin
        if (pick_found) begin
          job_is_cmd_d      = 1'b0;
          job_block_d       = pick_idx;
          job_res_d         = shadow_d[pick_idx];
          rr_ptr_d          = pick_idx;
          dirty_d[pick_idx] = 1'b0;
          state_d           = S_WAIT_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACC: if (job_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (job_done) begin
        if (!job_is_cmd_q) shown_d[job_block_q] = job_res_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (refresh) dirty_d = '1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      dp_vld_q     <= 1'b0;
      dp_wr_q      <= 1'b0;
      dp_addr_q    <= '0;
      enable_q     <= 1'b0;
      night_q      <= 1'b0;
      last_night_q <= 1'b0;
      shadow_q     <= '0;
      shown_q      <= '0;
      dirty_q      <= '0;
      rr_ptr_q     <= 5'(NUM_BLOCKS - 1);
      job_block_q  <= '0;
      job_res_q    <= '0;
      job_is_cmd_q <= 1'b0;
      job_cmd_q    <= 8'hA6;
    end else begin
      state_q      <= state_d;
      dp_vld_q     <= dp_vld_d;
      dp_wr_q      <= dp_wr_d;
      dp_addr_q    <= dp_addr_d;
      enable_q     <= enable_d;
      night_q      <= night_d;
      last_night_q <= last_night_d;
      shadow_q     <= shadow_d;
      shown_q      <= shown_d;
      dirty_q      <= dirty_d;
      rr_ptr_q     <= rr_ptr_d;
      job_block_q  <= job_block_d;
      job_res_q    <= job_res_d;
      job_is_cmd_q <= job_is_cmd_d;
      job_cmd_q    <= job_cmd_d;
    end
  end

endmodule

// File: doc/oled_update_scheduler.md
# oled_update_scheduler

Schedules OLED screen refreshes on the cycle computer SoC. The block sits between the AHB-Lite bus and the OLED pixel/SDI serializer. It holds the software-requested picture for every pixel block and tracks which blocks are out of date. It picks one stale block at a time, round-robin, and hands the serializer one job per block or per screen-mode command through a valid/ready/done handshake.

## Interface
- NUM_BLOCKS, 20, number of pixel blocks (1..32)
- RES_W, 5, resource (picture) index width
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite select / ready / write
- HTRANS  in  2  AHB transfer type; 2'b00 = no transfer
- HADDR  in  32  byte address; bits [7:2] decoded
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1; the block never inserts wait states
- job_valid  out  1  job offered to the serializer
- job_ready  in  1  serializer accepts the job this cycle
- job_done  in  1  one-cycle pulse when the accepted job has fully shifted out
- job_is_cmd  out  1  1 = single command byte, 0 = block draw
- job_cmd  out  8  command byte: 8'hA6 (day) or 8'hA7 (night)
- job_block  out  5  block index for a draw job
- job_resource  out  RES_W  resource index for a draw job
- busy  out  1  a job is offered or in flight

## Operation
- Memory map, word offsets:
  - 0x00 CTRL RW: bit0 enable. bit1 refresh_all, write-1 marks every block dirty and reads 0.
  - 0x04 STATUS RO: bit0 busy, bit1 any_dirty, bits[12:8] last served block.
  - 0x08 SCREEN RW: bit0 night.
  - 0x0C DIRTY RO: dirty bitmap, bits above NUM_BLOCKS read 0.
  - 0x40+4n BLOCK n RW: RES_W-bit shadow resource. Writes use HWDATA[RES_W-1:0], stored as-is.
- Writes to unmapped offsets or to n ≥ NUM_BLOCKS are ignored. Reads of those addresses return 0.
- Per block the block keeps shadow[n], shown[n] and dirty[n]. A BLOCK write sets dirty[n] = (new value != shown[n]). Writing back the shown value therefore cancels a pending update.
- FSM states:
  - IDLE → CMD when enable and night != last_night.
  - IDLE → PICK when enable and any dirty bit is set.
  - CMD → WAIT_ACC: job_is_cmd = 1 and last_night <= night. The command has priority over block jobs.
  - PICK: the round-robin encoder picks the first dirty block after rr_ptr, wrapping at NUM_BLOCKS-1 → 0. It latches job_block and job_resource = shadow, sets rr_ptr to that index, clears dirty for it, then goes to WAIT_ACC.
  - WAIT_ACC: job_valid = 1 and payload held stable until job_ready = 1, then WAIT_DONE.
  - WAIT_DONE: on job_done, shown[job_block] <= job_resource for draw jobs, then IDLE.
- A BLOCK n write while n is offered or in flight sets dirty[n] = (new value != latched job_resource), and the block is redrawn later.
- When a write and job_done for the same block land in the same cycle, dirty is computed against the latched resource.
- refresh_all written in the same cycle as a BLOCK write: refresh_all wins and every block becomes dirty.
- Clearing enable mid-job lets the current job complete. No new job is issued.
- Reset values: shadow, shown and dirty all 0. enable 0, night 0, last_night 0. rr_ptr = NUM_BLOCKS-1, so block 0 is the first candidate.
- Output reset values: job_valid, job_is_cmd, job_block, job_resource, busy and HRDATA all 0. job_cmd is 8'hA6. HREADYOUT is 1.
- Reset mid-job drops the job immediately, with no handshake completion.

## Timing
- AHB address phase is registered. The write takes effect at the clock edge ending the data phase, using HWDATA.
- HRDATA is combinational during the data phase, from the registered address.
- IDLE→PICK→WAIT_ACC: job_valid rises 2 cycles after the dirty bit is set.
- The handshake completes on the edge where job_valid and job_ready are both high. A ready arriving in the same cycle valid rises is legal.
- job_done is honoured only in WAIT_DONE. Elsewhere it is ignored.
- After job_done the next job_valid appears no earlier than 2 cycles later (IDLE, then PICK or CMD).
- busy = job_valid or state == WAIT_DONE.

## Test plan
- Reset, set enable, write BLOCK 3 = 7. Expect job_valid with job_block = 3 and job_resource = 7 two cycles later. Give ready, then done. Then shown[3] = 7 and DIRTY reads 0.
- Write blocks 2, 5 and 18 in one burst. Expect service order 2, 5, 18. Redirty block 2 while 5 is in flight. Expect order 2, 5, 18, 2.
- Write SCREEN = 1 while blocks 0 and 1 are dirty. The next job is job_is_cmd = 1 with job_cmd = 8'hA7, then blocks 0 and 1.
- Write BLOCK 4 = 9 during WAIT_DONE of block 4 with resource 6. After done, shown = 6 and dirty[4] = 1, and block 4 is reissued with 9. Writing 6 back instead clears dirty[4].
- With enable = 0, write refresh_all. Expect DIRTY = 0x000F_FFFF and no job_valid. Set enable: 20 jobs, indices 0..19.
- Hold job_ready low for 50 cycles. The payload stays stable. Assert HRESETn low mid-job: all outputs return to their reset values asynchronously.
